lutram_search: RTL

Sequential read-side search engine for the distributed-RAM CAM storage. On each request it walks every address of an external single-port LUTRAM through its combinational read port and compares each word to a key under a bit mask. It returns the lowest matching address, a hit flag and the total match count over a valid/ready response channel. It sits between the CAM lookup front end and the LUTRAM instance; the write path stays owned by the update logic.

---
 rtl/cam_pkg.sv | 6 +
 rtl/lutram_search_if.sv | 32 +++
 rtl/masked_match.sv | 13 +
 rtl/lutram_search.sv | 101 ++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared CAM definitions used by the search engine.
package cam_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} search_state_t;

endpackage

// File: rtl/lutram_search_if.sv
// Request/response and LUTRAM read-port bundle for lutram_search.
interface lutram_search_if #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 8
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);

  logic             req_valid;
  logic             req_ready;
  logic [Width-1:0] req_key;
  logic [Width-1:0] req_mask;
  logic [AddrW-1:0] ram_addr;
  logic [Width-1:0] ram_rdata;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_hit;
  logic [AddrW-1:0] resp_addr;
  logic [CntW-1:0]  resp_count;

  // Master issues requests, consumes results and supplies RAM read data.
  modport master (
    output req_valid, req_key, req_mask, resp_ready, ram_rdata,
    input  req_ready, ram_addr, resp_valid, resp_hit, resp_addr, resp_count
  );

  modport slave (
    input  req_valid, req_key, req_mask, resp_ready, ram_rdata,
    output req_ready, ram_addr, resp_valid, resp_hit, resp_addr, resp_count
  );

endinterface

// File: rtl/masked_match.sv
// Combinational masked compare: bits with mask=0 are don't-care.
module masked_match #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] data,
  input  logic [Width-1:0] key,
  input  logic [Width-1:0] mask,
  output logic             match
);

  assign match = ((data ^ key) & mask) == '0;

endmodule

// File: rtl/lutram_search.sv
// Sequential masked search over an external LUTRAM: one address per cycle,
// reports lowest matching address, hit flag and match count.
module lutram_search
  import cam_pkg::*;
#(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 8
) (
  input logic            clk,
  input logic            rst,
  lutram_search_if.slave bus
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  search_state_t    state_q, state_d;
  logic [Width-1:0] key_q, mask_q;
  logic [AddrW-1:0] addr_q, first_q;
  logic             hit_q;
  logic [CntW-1:0]  count_q;
  logic             match;

  masked_match #(
    .Width(Width)
  ) u_match (
    .data  (bus.ram_rdata),
    .key   (key_q),
    .mask  (mask_q),
    .match (match)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = SCAN;
      SCAN:    if (addr_q == LastAddr) state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers are cleared on accept and stay put outside SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      mask_q  <= '0;
      addr_q  <= '0;
      first_q <= '0;
      hit_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            key_q   <= bus.req_key;
            mask_q  <= bus.req_mask;
            addr_q  <= '0;
            first_q <= '0;
            hit_q   <= 1'b0;
            count_q <= '0;
          end
        end
        SCAN: begin
          if (match) begin
            count_q <= count_q + CntW'(1);
            if (!hit_q) begin
              hit_q   <= 1'b1;
              first_q <= addr_q;
            end
          end
          if (addr_q != LastAddr) addr_q <= addr_q + AddrW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_addr   = '0;
    case (state_q)
      IDLE:    bus.req_ready  = !rst;
      SCAN:    bus.ram_addr   = addr_q;
      RESP:    bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_hit   = hit_q;
  assign bus.resp_addr  = first_q;
  assign bus.resp_count = count_q;

endmodule
